// File: rtl/sistema_keys_pio_pkg.sv
// rtl/sistema_keys_pio_pkg.sv - register map, edge-type codes and edge qualifier for the keys PIO
package sistema_keys_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RESERVED = 2'd1,
    ADDR_IRQMASK  = 2'd2,
    ADDR_EDGE     = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_event(input int edge_type, input logic rise, input logic fall);
    if (edge_type == EDGE_RISE) return rise;
    if (edge_type == EDGE_FALL) return fall;
    return rise | fall;
  endfunction

endpackage

// File: rtl/sistema_keys_pio_if.sv
// rtl/sistema_keys_pio_if.sv - Avalon-MM slave bus plus interrupt line of the keys PIO
interface sistema_keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/sistema_keys_pio_debounce_bit.sv
// rtl/sistema_keys_pio_debounce_bit.sv - one key: 2-FF synchronizer, stability counter, debounced FF
module sistema_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, stable_q, accept;
  logic [CW-1:0] cnt;

  // accept fires on the cycle whose closing edge flips stable_q
  assign accept = (sync2 != stable_q) && (cnt == CNT_MAX);
  assign rise   = accept & sync2;
  assign fall   = accept & ~sync2;
  assign stable = stable_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= RESET_LEVEL;
      sync2    <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      cnt      <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == stable_q) begin
        cnt <= '0;
      end else if (accept) begin
        stable_q <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sistema_keys_pio.sv
// rtl/sistema_keys_pio.sv - debounced input PIO with edge capture, irq mask and register read mux
module sistema_keys_pio
  import sistema_keys_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  sistema_keys_pio_if.slave bus
);
  logic [WIDTH-1:0] stable, rise, fall, evt, mask, edge_cap, clr;
  logic [31:0]      rdata;
  logic             wr;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sistema_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[gi])
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[gi]),
      .stable (stable[gi]),
      .rise   (rise[gi]),
      .fall   (fall[gi])
    );
    assign evt[gi] = edge_event(EDGE_TYPE, rise[gi], fall[gi]);
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:WIDTH];
  end

  assign wr  = bus.chipselect & ~bus.write_n;
  assign clr = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  // a fresh event on the same bit outranks the W1C clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask     <= '0;
      edge_cap <= '0;
    end else begin
      if (wr && bus.address == ADDR_IRQMASK) mask <= bus.writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr) | evt;
    end
  end

  always_comb begin
    rdata = '0;
    case (pio_addr_e'(bus.address))
      ADDR_DATA:     rdata[WIDTH-1:0] = stable;
      ADDR_IRQMASK:  rdata[WIDTH-1:0] = mask;
      ADDR_EDGE:     rdata[WIDTH-1:0] = edge_cap;
      default:       rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign bus.irq      = |(edge_cap & mask);
endmodule
